// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receiver slice:
//   - rx_state_t      : receiver FSM states (IDLE, DATA, STOP)
//   - DEFAULT_DATAWIDTH : default number of data bits per frame
//   - cnt_width()     : bit-counter width for a given data width; the counter
//                       must be able to hold DATAWIDTH itself without wrapping
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } rx_state_t;

    localparam int DEFAULT_DATAWIDTH = 8;

    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage : uart_rx_pkg

// File: rtl/rx_bit_shifter.sv
// -----------------------------------------------------------------------------
// rx_bit_shifter
// Receive shift register plus bit counter.
//   clk        : rising-edge clock
//   rst        : synchronous active-low reset (clears register and counter)
//   clear      : zero the bit counter (start of a new frame)
//   shift      : shift serial_in into the MSB (right shift), count one bit
//   serial_in  : sampled UART line
//   shift_data : current shift-register contents
//   bit_cnt    : number of data bits shifted in since the last clear
// With neither clear nor shift asserted, everything holds.
// -----------------------------------------------------------------------------
module rx_bit_shifter
    import uart_rx_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter int CNT_W     = cnt_width(DATAWIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 shift,
    input  logic                 serial_in,
    output logic [DATAWIDTH-1:0] shift_data,
    output logic [CNT_W-1:0]     bit_cnt
);

    logic [DATAWIDTH-1:0] sr_reg;
    logic [CNT_W-1:0]     cnt_reg;

    // LSB-first framing: each new bit enters at the MSB and the older bits
    // move one place toward bit 0, so after DATAWIDTH shifts the first
    // received bit sits in bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < DATAWIDTH; gi++) begin : g_sr
            if (gi == DATAWIDTH - 1) begin : g_msb
                always_ff @(posedge clk) begin
                    if (!rst) begin
                        sr_reg[gi] <= 1'b0;
                    end else if (shift) begin
                        sr_reg[gi] <= serial_in;
                    end
                end
            end else begin : g_low
                always_ff @(posedge clk) begin
                    if (!rst) begin
                        sr_reg[gi] <= 1'b0;
                    end else if (shift) begin
                        sr_reg[gi] <= sr_reg[gi+1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (shift) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign shift_data = sr_reg;
    assign bit_cnt    = cnt_reg;

endmodule : rx_bit_shifter

// File: rtl/rx_top_module.sv
// -----------------------------------------------------------------------------
// rx_top_module
// UART receiver: 1 start bit, DATAWIDTH data bits LSB first, 1 stop bit.
//   clk       : rising-edge clock
//   rst       : synchronous active-low reset
//   serial_in : UART line (already synchronised, idle high)
//   bit_enb   : bit-rate strobe; one line sample per clock with bit_enb=1
//   RX_DATA   : last accepted data word (registered, held between frames)
//   RX_DONE   : one-clock pulse, the clock after the stop-bit sample
// Build option: define RX_FRAME_CHECK_EN to discard frames whose stop-bit
// sample is 0. Without it, the stop-bit sample is ignored.
// -----------------------------------------------------------------------------
module rx_top_module
    import uart_rx_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 bit_enb,
    output logic [DATAWIDTH-1:0] RX_DATA,
    output logic                 RX_DONE
);

    localparam int CNT_W = cnt_width(DATAWIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATAWIDTH - 1);

    rx_state_t            state_reg;
    logic [DATAWIDTH-1:0] rx_data_reg;
    logic                 rx_done_reg;

    logic                 clear;
    logic                 shift;
    logic                 stop_ok;
    logic [DATAWIDTH-1:0] shift_data;
    logic [CNT_W-1:0]     bit_cnt;

    // Shifter controls must act on the same edge as the FSM decision,
    // so they are decoded combinationally from the current state.
    always_comb begin
        clear = 1'b0;
        shift = 1'b0;
        if (bit_enb) begin
            case (state_reg)
                IDLE:    clear = ~serial_in;
                DATA:    shift = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef RX_FRAME_CHECK_EN
    assign stop_ok = serial_in;
`else
    assign stop_ok = 1'b1;
`endif

    rx_bit_shifter #(
        .DATAWIDTH (DATAWIDTH),
        .CNT_W     (CNT_W)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .shift      (shift),
        .serial_in  (serial_in),
        .shift_data (shift_data),
        .bit_cnt    (bit_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            rx_data_reg <= '0;
            rx_done_reg <= 1'b0;
        end else begin
            rx_done_reg <= 1'b0;
            if (bit_enb) begin
                case (state_reg)
                    IDLE: begin
                        if (!serial_in) begin
                            state_reg <= DATA;
                        end
                    end
                    DATA: begin
                        // bit_cnt still shows the count before this sample
                        if (bit_cnt == LAST_CNT) begin
                            state_reg <= STOP;
                        end
                    end
                    STOP: begin
                        state_reg <= IDLE;
                        if (stop_ok) begin
                            rx_data_reg <= shift_data;
                            rx_done_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign RX_DATA = rx_data_reg;
    assign RX_DONE = rx_done_reg;

endmodule : rx_top_module

// File: tb/tb_rx_top_module.sv
// -----------------------------------------------------------------------------
// tb_rx_top_module
// Directed-vector bench for rx_top_module (DATAWIDTH = 8). Expected values are
// hand-computed constants; RX_DONE pulses are counted on the falling edge and
// the RX_DATA value seen with each pulse is logged.
// Honours RX_FRAME_CHECK_EN for the bad-stop-bit frame.
// -----------------------------------------------------------------------------
module tb_rx_top_module;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serial_in = 1'b1;
    logic       bit_enb = 1'b0;
    logic [7:0] RX_DATA;
    logic       RX_DONE;

    int tests_run = 0;
    int tests_failed = 0;

    int         done_cnt = 0;
    logic [7:0] data_log [0:15];

    always #5 clk = ~clk;

    rx_top_module #(.DATAWIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .bit_enb   (bit_enb),
        .RX_DATA   (RX_DATA),
        .RX_DONE   (RX_DONE)
    );

    // Every clock with RX_DONE high counts, so a stretched pulse shows up
    // as an extra count.
    always @(negedge clk) begin
        if (RX_DONE) begin
            data_log[done_cnt % 16] = RX_DATA;
            done_cnt = done_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, obs);
        end
    endtask

    // One bit period: strobe for one clock with the bit value, then
    // (period-1) clocks without strobe and the line inverted, so any
    // sample taken off-strobe corrupts the word.
    task automatic tick(input logic b, input int period);
        serial_in = b;
        bit_enb   = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k < period; k++) begin
            serial_in = ~b;
            bit_enb   = 1'b0;
            @(posedge clk); #1;
        end
        bit_enb = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int period);
        tick(1'b0, period);
        for (int i = 0; i < 8; i++) tick(d[i], period);
        tick(stop_b, period);
    endtask

    task automatic idle_clocks(input int n);
        serial_in = 1'b1;
        bit_enb   = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    int base;

    initial begin
        // Reset with strobe and a low line, to show reset wins.
        rst = 1'b0; bit_enb = 1'b1; serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bit_enb = 1'b0; serial_in = 1'b1;
        @(negedge clk);
        check_val("reset_data", 32'(RX_DATA), 32'h00);
        check_val("reset_done", 32'(RX_DONE), 32'h0);
        rst = 1'b1;
        idle_clocks(2);

        // 8'hAA, strobe every clock
        base = done_cnt;
        send_frame(8'hAA, 1'b1, 1);
        idle_clocks(3);
        check_val("aa_pulses", 32'(done_cnt - base), 32'd1);
        check_val("aa_data", 32'(RX_DATA), 32'hAA);
        check_val("aa_log", 32'(data_log[base % 16]), 32'hAA);

        // 8'h3C, strobe every 4 clocks
        base = done_cnt;
        send_frame(8'h3C, 1'b1, 4);
        idle_clocks(3);
        check_val("3c_pulses", 32'(done_cnt - base), 32'd1);
        check_val("3c_data", 32'(RX_DATA), 32'h3C);

        // Back-to-back 8'h55, 8'h0F
        base = done_cnt;
        send_frame(8'h55, 1'b1, 1);
        send_frame(8'h0F, 1'b1, 1);
        idle_clocks(3);
        check_val("b2b_pulses", 32'(done_cnt - base), 32'd2);
        check_val("b2b_first", 32'(data_log[base % 16]), 32'h55);
        check_val("b2b_second", 32'(data_log[(base + 1) % 16]), 32'h0F);

        // 8'hC3 with a bad stop bit
        base = done_cnt;
        send_frame(8'hC3, 1'b0, 1);
        idle_clocks(3);
`ifdef RX_FRAME_CHECK_EN
        check_val("c3_pulses", 32'(done_cnt - base), 32'd0);
        check_val("c3_data", 32'(RX_DATA), 32'h0F);
`else
        check_val("c3_pulses", 32'(done_cnt - base), 32'd1);
        check_val("c3_data", 32'(RX_DATA), 32'hC3);
`endif

        // Boundary words, strobe every 2 clocks
        send_frame(8'hFF, 1'b1, 2);
        idle_clocks(2);
        check_val("ff_data", 32'(RX_DATA), 32'hFF);
        send_frame(8'h00, 1'b1, 2);
        idle_clocks(2);
        check_val("00_data", 32'(RX_DATA), 32'h00);
        send_frame(8'hA5, 1'b1, 1);
        idle_clocks(2);
        check_val("a5_data", 32'(RX_DATA), 32'hA5);

        // Reset after 4 data bits, then a full 8'h81 frame
        base = done_cnt;
        tick(1'b0, 1);
        tick(1'b1, 1); tick(1'b1, 1); tick(1'b0, 1); tick(1'b1, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_data", 32'(RX_DATA), 32'h00);
        idle_clocks(3);
        check_val("abort_pulses", 32'(done_cnt - base), 32'd0);
        check_val("abort_hold", 32'(RX_DATA), 32'h00);
        send_frame(8'h81, 1'b1, 1);
        idle_clocks(3);
        check_val("81_pulses", 32'(done_cnt - base), 32'd1);
        check_val("81_data", 32'(RX_DATA), 32'h81);

        // No strobe for 20 clocks while the line toggles
        base = done_cnt;
        bit_enb = 1'b0;
        for (int i = 0; i < 20; i++) begin
            serial_in = i[0];
            @(posedge clk); #1;
        end
        idle_clocks(2);
        check_val("nostrobe_pulses", 32'(done_cnt - base), 32'd0);
        check_val("nostrobe_data", 32'(RX_DATA), 32'h81);
        // Receiver must still be in IDLE: a fresh frame decodes cleanly.
        send_frame(8'h6E, 1'b1, 1);
        idle_clocks(3);
        check_val("after_pulses", 32'(done_cnt - base), 32'd1);
        check_val("after_data", 32'(RX_DATA), 32'h6E);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_rx_top_module
